// File: rtl/fifo_arbiter.sv
// fifo_arbiter: round-robin drain of NUM_Q registered-read input FIFOs into
// one downstream FIFO, with back-pressure from the downstream almost_full.
`timescale 1ns/1ps
module fifo_arbiter #(
    parameter int NUM_Q = 4,
    parameter int DW    = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_Q-1:0]    q_empty,
    input  logic [NUM_Q*DW-1:0] q_data,
    output logic [NUM_Q-1:0]    q_pop,
    input  logic                out_almost_full,
    output logic                out_push,
    output logic [DW-1:0]       out_data,
    output logic [1:0]          arb_state,
    output logic [15:0]         words_sent
);

    localparam int PW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_Q-1:0] prev_pop_q, prev_pop_d;
    logic             push_q, push_d;
    logic [PW-1:0]    pop_idx_q, pop_idx_d;
    logic [DW-1:0]    data_hold_q, data_hold_d;
    logic [15:0]      words_sent_q, words_sent_d;

    logic [DW-1:0]    q_word [NUM_Q];
    logic [NUM_Q-1:0] eligible;
    logic             grant_vld;
    logic [PW-1:0]    grant_idx;
    logic [PW-1:0]    cand;
    logic             pop_ok;

    // Unpack the flattened FIFO data buses into one word per queue.
    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            q_word[i] = q_data[i*DW +: DW];
        end
    end

    // Round-robin grant: a queue popped last cycle is skipped because its
    // empty flag has not yet caught up with that pop.
    always_comb begin
        eligible  = ~q_empty & ~prev_pop_q;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_Q; k++) begin
            cand = PW'((int'(rr_ptr_q) + k) % NUM_Q);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        pop_ok = enable && !out_almost_full && !reset && grant_vld;
        q_pop  = '0;
        if (pop_ok) begin
            q_pop[grant_idx] = 1'b1;
        end
    end

    // Next-state, pointer, in-flight tracking and output datapath.
    always_comb begin
        state_d = IDLE;
        if (pop_ok) begin
            state_d = RUN;
        end else if (enable && grant_vld && out_almost_full) begin
            state_d = STALL;
        end

        rr_ptr_d = rr_ptr_q;
        if (pop_ok) begin
            rr_ptr_d = (grant_idx == PW'(NUM_Q - 1)) ? '0 : PW'(grant_idx + 1'b1);
        end

        prev_pop_d = q_pop;
        push_d     = pop_ok;
        pop_idx_d  = pop_ok ? grant_idx : pop_idx_q;

        // A word in flight while reset is held is dropped, not pushed.
        out_push     = push_q && !reset;
        out_data     = out_push ? q_word[pop_idx_q] : data_hold_q;
        data_hold_d  = out_data;
        words_sent_d = words_sent_q + {15'd0, out_push};
    end

    // Control and held-output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            prev_pop_q   <= '0;
            push_q       <= 1'b0;
            data_hold_q  <= '0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            prev_pop_q   <= prev_pop_d;
            push_q       <= push_d;
            data_hold_q  <= data_hold_d;
            words_sent_q <= words_sent_d;
        end
    end

    // Index of the popped queue; only meaningful alongside push_q.
    always_ff @(posedge clk) begin
        pop_idx_q <= pop_idx_d;
    end

    assign arb_state  = state_q;
    assign words_sent = words_sent_q;

endmodule
